// File: rtl/fetch_queue_stage_if.sv
// Handshake bundle between inst_mem/branch predictor, the fetch queue stage and decode.
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_queue_stage_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INST_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_inst;
    logic                  bp_taken;
    logic [PC_WIDTH-1:0]   bp_target;
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  stall;
    logic                  out_valid;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [INST_WIDTH-1:0] out_inst;
    logic                  out_pred_taken;
    logic [CNT_W-1:0]      queue_count;

    modport master (
        output imem_addr,
        input  imem_inst, bp_taken, bp_target, redirect_valid, redirect_pc, stall,
        output out_valid, out_pc, out_inst, out_pred_taken, queue_count
    );

    modport slave (
        input  imem_addr,
        output imem_inst, bp_taken, bp_target, redirect_valid, redirect_pc, stall,
        input  out_valid, out_pc, out_inst, out_pred_taken, queue_count
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with a circular fetch queue and registered head-of-queue output.
// Define FETCH_QUEUE_PERF_EN to add the flush / full-cycle performance counters.
module fetch_queue_stage #(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST    = INST_WIDTH'(32'h00000013)
) (
    input  logic                clk,
    input  logic                rst,
    fetch_queue_stage_if.master fq
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perf_flush_cnt,
    output logic [31:0]         perf_full_cycles
`endif
);
    localparam int               PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {
        RUN,
        HOLD
    } state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  out_valid;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [INST_WIDTH-1:0] out_inst;
    logic                  out_pred;

    logic [PC_WIDTH-1:0]   entry_pc   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0] entry_inst [QUEUE_DEPTH];
    logic                  entry_pred [QUEUE_DEPTH];

    logic                  pred_taken;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic [CNT_W-1:0]      remaining;

    logic [PC_WIDTH-1:0]   head_pc;
    logic [INST_WIDTH-1:0] head_inst;
    logic                  head_pred;

    // bp_taken only counts for branches (opcode bit 6 set).
    assign pred_taken = fq.imem_inst[6] & fq.bp_taken;
    assign full       = (count == FULL_CNT);
    assign pop        = out_valid & ~fq.stall;
    // HOLD implies full, so the state term freezes fetch until decode drains an entry.
    assign push       = ~fq.redirect_valid & (((state == RUN) & ~full) | pop);
    assign pc_nxt     = pred_taken ? fq.bp_target : pc + PC_WIDTH'(4);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    assign wr_ptr_nxt = wr_ptr + PTR_W'(push);
    assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    assign remaining  = count - CNT_W'(pop);

    // Next head: the freshly fetched entry if nothing older survives, else the stored one.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head_pc   = '0;
        head_inst = NOP_INST;
        head_pred = 1'b0;
        if (count_nxt != '0) begin
            if (remaining == '0) begin
                head_pc   = pc;
                head_inst = fq.imem_inst;
                head_pred = pred_taken;
            end else begin
                head_pc   = entry_pc[rd_ptr_nxt];
                head_inst = entry_inst[rd_ptr_nxt];
                head_pred = entry_pred[rd_ptr_nxt];
            end
        end
    end

    // NOTE: queue storage has no reset; count/pointers define validity, which keeps it RAM-friendly.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_pc[wr_ptr]   <= pc;
            entry_inst[wr_ptr] <= fq.imem_inst;
            entry_pred[wr_ptr] <= pred_taken;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
            out_pred  <= 1'b0;
        end else if (fq.redirect_valid) begin
            state     <= RUN;
            pc        <= fq.redirect_pc;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
            out_pred  <= 1'b0;
        end else begin
            state     <= ((count_nxt == FULL_CNT) && !pop) ? HOLD : RUN;
            if (push) pc <= pc_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            out_pc    <= head_pc;
            out_inst  <= head_inst;
            out_pred  <= head_pred;
        end
    end

    assign fq.imem_addr      = pc;
    assign fq.out_valid      = out_valid;
    assign fq.out_pc         = out_pc;
    assign fq.out_inst       = out_inst;
    assign fq.out_pred_taken = out_pred;
    assign fq.queue_count    = count;

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_flush_cnt   <= '0;
            perf_full_cycles <= '0;
        end else begin
            if (fq.redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if ((state == HOLD) && (perf_full_cycles != '1))
                perf_full_cycles <= perf_full_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed vector table, async-reset check,
// and a randomized run against a queue-based reference model.
module tb_fetch_queue_stage;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   rand_br = 1'b0;
    bit   br_en   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_queue_stage_if #(.PC_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(DEPTH)) fq ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_full_cycles;
`endif

    fetch_queue_stage #(
        .PC_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(DEPTH),
        .RESET_PC(32'h0), .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fq(fq)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_flush_cnt(perf_flush_cnt),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: non-branch by default; bit 6 marks a branch.
    function automatic logic [31:0] imem_fn(logic [31:0] a, bit rb, bit be);
        logic [31:0] r;
        r = {a[26:2], 7'h13};
        if (rb) r[6] = ^a[9:2];
        else if (be && a == 32'h8) r[6] = 1'b1;
        return r;
    endfunction

    assign fq.imem_inst = imem_fn(fq.imem_addr, rand_br, br_en);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          do_rst;
        bit          br;
        bit          st;
        bit          rdr;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        bit          epred;
        int          ecnt;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];

    initial begin
        logic [31:0] mpc;
        logic [31:0] exp_inst;

        fq.stall = 1'b0; fq.redirect_valid = 1'b0; fq.redirect_pc = '0;
        fq.bp_taken = 1'b1; fq.bp_target = 32'h40;

        // {rst, br, stall, redirect, redirect_pc, exp_valid, exp_pc, exp_pred, exp_count, exp_addr}
        // Predicted-taken branch at 0x8 -> 0x40 with no bubble.
        vecs.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h00, 0, 0, 32'h00});
        vecs.push_back('{0, 1, 0, 0, 32'h0, 1, 32'h00, 0, 1, 32'h04});
        vecs.push_back('{0, 1, 0, 0, 32'h0, 1, 32'h04, 0, 1, 32'h08});
        vecs.push_back('{0, 1, 0, 0, 32'h0, 1, 32'h08, 1, 1, 32'h40});
        vecs.push_back('{0, 1, 0, 0, 32'h0, 1, 32'h40, 0, 1, 32'h44});
        vecs.push_back('{0, 1, 0, 0, 32'h0, 1, 32'h44, 0, 1, 32'h48});
        // Fill under a 6-cycle stall, drain while full, then redirect while full and stalled.
        vecs.push_back('{1, 0, 1, 0, 32'h0, 0, 32'h00, 0, 0, 32'h00});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 1, 32'h00, 0, 1, 32'h04});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 1, 32'h00, 0, 2, 32'h08});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 1, 32'h00, 0, 3, 32'h0C});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 1, 32'h00, 0, 4, 32'h10});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 1, 32'h00, 0, 4, 32'h10});
        vecs.push_back('{0, 0, 0, 0, 32'h0, 1, 32'h00, 0, 4, 32'h10});
        vecs.push_back('{0, 0, 0, 0, 32'h0, 1, 32'h04, 0, 4, 32'h14});
        vecs.push_back('{0, 0, 0, 0, 32'h0, 1, 32'h08, 0, 4, 32'h18});
        vecs.push_back('{0, 0, 0, 0, 32'h0, 1, 32'h0C, 0, 4, 32'h1C});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 1, 32'h10, 0, 4, 32'h20});
        vecs.push_back('{0, 0, 1, 1, 32'h100, 1, 32'h10, 0, 4, 32'h20});
        vecs.push_back('{0, 0, 1, 0, 32'h0, 0, 32'h00, 0, 0, 32'h100});
        vecs.push_back('{0, 0, 0, 0, 32'h0, 1, 32'h100, 0, 1, 32'h104});
        vecs.push_back('{0, 0, 0, 0, 32'h0, 1, 32'h104, 0, 1, 32'h108});

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].do_rst) begin
                rst = 1'b1; #1; rst = 1'b0;
            end
            br_en = vecs[i].br;
            fq.stall          = vecs[i].st;
            fq.redirect_valid = vecs[i].rdr;
            fq.redirect_pc    = vecs[i].rpc;
            #1;
            exp_inst = vecs[i].ev ? imem_fn(vecs[i].epc, 1'b0, vecs[i].br) : NOP;
            check($sformatf("vec%0d valid", i), 32'(fq.out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d pc", i), fq.out_pc, vecs[i].epc);
            check($sformatf("vec%0d inst", i), fq.out_inst, exp_inst);
            check($sformatf("vec%0d pred", i), 32'(fq.out_pred_taken), 32'(vecs[i].epred));
            check($sformatf("vec%0d count", i), 32'(fq.queue_count), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d addr", i), fq.imem_addr, vecs[i].eaddr);
        end

        // Asynchronous reset between clock edges takes effect with no edge.
        @(negedge clk);
        fq.redirect_valid = 1'b0; fq.stall = 1'b0;
        #2;
        check("pre_rst valid", 32'(fq.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst valid", 32'(fq.out_valid), 32'd0);
        check("async_rst addr", fq.imem_addr, 32'h0);
        check("async_rst count", 32'(fq.queue_count), 32'd0);
        check("async_rst inst", fq.out_inst, NOP);
        rst = 1'b0;

        // Randomized run against a queue-based reference model.
        @(negedge clk);
        rand_br = 1'b1; br_en = 1'b0;
        fq.stall = 1'b0; fq.redirect_valid = 1'b0;
        rst = 1'b1; #1; rst = 1'b0;
        mq.delete();
        mpc = 32'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ent_t e;
            bit   do_pop;
            fq.stall          = ($urandom % 100) < 40;
            fq.redirect_valid = ($urandom % 100) < 5;
            fq.redirect_pc    = 32'($urandom_range(0, 65535)) & 32'hFFFF_FFFC;
            fq.bp_taken       = $urandom % 2;
            fq.bp_target      = 32'($urandom_range(0, 65535)) & 32'hFFFF_FFFC;
            #1;
            check("rnd valid", 32'(fq.out_valid), 32'(mq.size() != 0));
            check("rnd pc", fq.out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
            check("rnd inst", fq.out_inst, (mq.size() != 0) ? mq[0].inst : NOP);
            check("rnd pred", 32'(fq.out_pred_taken), (mq.size() != 0) ? 32'(mq[0].pred) : 32'd0);
            check("rnd count", 32'(fq.queue_count), 32'(mq.size()));
            check("rnd addr", fq.imem_addr, mpc);

            e.pc   = mpc;
            e.inst = imem_fn(mpc, 1'b1, 1'b0);
            e.pred = e.inst[6] & fq.bp_taken;
            do_pop = (mq.size() != 0) && !fq.stall;
            if (fq.redirect_valid) begin
                mq.delete();
                mpc = fq.redirect_pc;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                    mpc = e.pred ? fq.bp_target : mpc + 32'd4;
                end
            end
            @(negedge clk);
        end

`ifdef FETCH_QUEUE_PERF_EN
        // Five HOLD cycles (full and stalled, plus the draining cycle), then three redirects.
        rand_br = 1'b0; br_en = 1'b0;
        fq.stall = 1'b1; fq.redirect_valid = 1'b0; fq.redirect_pc = 32'h200;
        rst = 1'b1; #1; rst = 1'b0;
        check("perf flush reset", perf_flush_cnt, 32'd0);
        check("perf full reset", perf_full_cycles, 32'd0);
        for (int c = 0; c < 12; c++) begin
            fq.stall          = (c < 8);
            fq.redirect_valid = (c >= 9) && (c <= 11);
            @(negedge clk);
        end
        fq.redirect_valid = 1'b0;
        #1;
        check("perf flush", perf_flush_cnt, 32'd3);
        check("perf full", perf_full_cycles, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
